pipe_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage PipelinedCpu (IF/ID/EX/MEM/WB). It decides, every cycle, which pipeline registers load, hold or are bubbled: load-use stalls, taken-branch flushes, data-memory wait freezes, and halt. It also keeps saturating performance counters. It sits beside the datapath and drives only the write-enable and flush controls of the PC and the stage registers.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/hazard_detect.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller.
//   ctrl_state_e : controller FSM states
//   RA_W         : default register-index width
//   ZERO_REG     : architectural zero register (writes to it are discarded)
package pipe_ctrl_pkg;

    localparam int unsigned RA_W     = 5;
    localparam int unsigned ZERO_REG = 0;

    typedef enum logic [1:0] {
        StRun,
        StFreeze,
        StFlushPend,
        StHalt
    } ctrl_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection (purely combinational).
//   id_rs_i/id_rt_i         : source registers of the ID instruction
//   id_use_rs_i/id_use_rt_i : ID instruction really reads that source
//   ex_rd_i                 : destination of the EX instruction
//   ex_memread_i            : EX instruction is a load
//   lu_o                    : ID must wait one cycle for the load data
module hazard_detect #(
    parameter int unsigned RegW = pipe_ctrl_pkg::RA_W
) (
    input  logic [RegW-1:0] id_rs_i,
    input  logic [RegW-1:0] id_rt_i,
    input  logic            id_use_rs_i,
    input  logic            id_use_rt_i,
    input  logic [RegW-1:0] ex_rd_i,
    input  logic            ex_memread_i,
    output logic            lu_o
);
    import pipe_ctrl_pkg::*;

    logic rd_live;
    logic rs_hit;
    logic rt_hit;

    // A load into the zero register never produces a value worth waiting for.
    assign rd_live = (ex_rd_i != RegW'(ZERO_REG));
    assign rs_hit  = id_use_rs_i && (id_rs_i == ex_rd_i);
    assign rt_hit  = id_use_rt_i && (id_rt_i == ex_rd_i);
    assign lu_o    = ex_memread_i && rd_live && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline.
// Decides each cycle which pipeline registers load, hold or get bubbled.
//   CLK, RST              : clock, asynchronous active-low reset
//   id_rs/id_rt, id_use_* : ID source operands and their use flags
//   ex_rd, ex_memread     : EX destination and load flag
//   ex_br_taken           : branch resolved taken in EX
//   mem_busy              : data memory not ready, freeze the pipe
//   wb_halt               : halt instruction is in WB
//   pc_we, ifid_we        : front-end load enables
//   ifid_flush            : clear IF/ID to NOP
//   idex_bubble           : load NOP into ID/EX
//   back_we               : EX/MEM and MEM/WB load enable
//   halted                : core stopped
//   stall_cnt, flush_cnt  : saturating event counters
module pipe_hazard_ctrl #(
    parameter int unsigned RA_W  = pipe_ctrl_pkg::RA_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic             ex_memread,
    input  logic             ex_br_taken,
    input  logic             mem_busy,
    input  logic             wb_halt,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             back_we,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    import pipe_ctrl_pkg::*;

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             stall_inc;
    logic             flush_inc;
    logic             lu;

    hazard_detect #(
        .RegW (RA_W)
    ) u_hazard_detect (
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_use_rs_i  (id_use_rs),
        .id_use_rt_i  (id_use_rt),
        .ex_rd_i      (ex_rd),
        .ex_memread_i (ex_memread),
        .lu_o         (lu)
    );

    always_comb begin
        state_d     = state_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        back_we     = 1'b0;

        unique case (state_q)
            // FREEZE only differs from RUN while mem_busy is high, and both
            // freeze identically then, so they share one decode.
            StRun, StFreeze: begin
                if (mem_busy) begin
                    stall_inc = 1'b1;
                    state_d   = ex_br_taken ? StFlushPend : StFreeze;
                end else if (ex_br_taken) begin
                    // Branch beats load-use: the stalled ID instruction is
                    // squashed anyway.
                    pc_we       = 1'b1;
                    ifid_we     = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    back_we     = 1'b1;
                    flush_inc   = 1'b1;
                    state_d     = StRun;
                end else if (lu) begin
                    idex_bubble = 1'b1;
                    back_we     = 1'b1;
                    stall_inc   = 1'b1;
                    state_d     = StRun;
                end else begin
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                    back_we = 1'b1;
                    state_d = StRun;
                end
            end
            // The held EX instruction is the latched branch, so ex_br_taken
            // carries no new information here.
            StFlushPend: begin
                if (mem_busy) begin
                    stall_inc = 1'b1;
                end else begin
                    pc_we       = 1'b1;
                    ifid_we     = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    back_we     = 1'b1;
                    flush_inc   = 1'b1;
                    state_d     = StRun;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StRun;
            end
        endcase

        if (wb_halt && (state_q != StHalt)) begin
            state_d = StHalt;
        end

        // Hold the pipe empty while reset is asserted.
        if (!RST) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            back_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StRun;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign halted    = (state_q == StHalt);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int unsigned RA_W    = 5;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = 15;

    logic            CLK;
    logic            RST;
    logic [RA_W-1:0] id_rs;
    logic [RA_W-1:0] id_rt;
    logic            id_use_rs;
    logic            id_use_rt;
    logic [RA_W-1:0] ex_rd;
    logic            ex_memread;
    logic            ex_br_taken;
    logic            mem_busy;
    logic            wb_halt;
    logic            pc_we;
    logic            ifid_we;
    logic            ifid_flush;
    logic            idex_bubble;
    logic            back_we;
    logic            halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int checks;
    int errors;

    // Reference model: "halted", "a branch is waiting for memory", and two
    // plain integer counters.
    bit m_halted;
    bit m_pend;
    int m_stall;
    int m_flush;
    // Per-cycle expectations
    bit e_pc, e_ifwe, e_fl, e_bub, e_back;
    bit e_inc_stall, e_inc_flush, e_nxt_pend, e_nxt_halt;

    pipe_hazard_ctrl #(
        .RA_W  (RA_W),
        .CNT_W (CNT_W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_use_rs   (id_use_rs),
        .id_use_rt   (id_use_rt),
        .ex_rd       (ex_rd),
        .ex_memread  (ex_memread),
        .ex_br_taken (ex_br_taken),
        .mem_busy    (mem_busy),
        .wb_halt     (wb_halt),
        .pc_we       (pc_we),
        .ifid_we     (ifid_we),
        .ifid_flush  (ifid_flush),
        .idex_bubble (idex_bubble),
        .back_we     (back_we),
        .halted      (halted),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_in(input int rs, input int rt, input bit urs, input bit urt, input int rd,
                          input bit mr, input bit br, input bit busy, input bit hlt);
        id_rs       = RA_W'(rs);
        id_rt       = RA_W'(rt);
        id_use_rs   = urs;
        id_use_rt   = urt;
        ex_rd       = RA_W'(rd);
        ex_memread  = mr;
        ex_br_taken = br;
        mem_busy    = busy;
        wb_halt     = hlt;
    endtask

    task automatic set_idle();
        set_in(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        m_halted = 1'b0;
        m_pend   = 1'b0;
        m_stall  = 0;
        m_flush  = 0;
    endtask

    task automatic model_eval();
        bit lu_m;
        lu_m = ex_memread && (ex_rd != 0) &&
               ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
        {e_pc, e_ifwe, e_fl, e_bub, e_back} = 5'b0;
        e_inc_stall = 1'b0;
        e_inc_flush = 1'b0;
        e_nxt_pend  = m_pend;
        e_nxt_halt  = m_halted;
        if (m_halted) begin
            // stopped: nothing moves
        end else if (mem_busy) begin
            e_inc_stall = 1'b1;
            e_nxt_pend  = m_pend || ex_br_taken;
        end else if (m_pend || ex_br_taken) begin
            {e_pc, e_ifwe, e_fl, e_bub, e_back} = 5'b11111;
            e_inc_flush = 1'b1;
            e_nxt_pend  = 1'b0;
        end else if (lu_m) begin
            e_bub       = 1'b1;
            e_back      = 1'b1;
            e_inc_stall = 1'b1;
        end else begin
            e_pc   = 1'b1;
            e_ifwe = 1'b1;
            e_back = 1'b1;
        end
        if (!m_halted && wb_halt) e_nxt_halt = 1'b1;
    endtask

    task automatic model_commit();
        if (e_inc_stall && m_stall < CNT_MAX) m_stall++;
        if (e_inc_flush && m_flush < CNT_MAX) m_flush++;
        m_pend   = e_nxt_pend;
        m_halted = e_nxt_halt;
    endtask

    // Inputs are already driven; called just after a rising edge.
    task automatic run_cycle(input string tag);
        @(negedge CLK);
        model_eval();
        check_eq({tag, ".pc_we"}, 32'(pc_we), 32'(e_pc));
        check_eq({tag, ".ifid_we"}, 32'(ifid_we), 32'(e_ifwe));
        check_eq({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(e_fl));
        check_eq({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(e_bub));
        check_eq({tag, ".back_we"}, 32'(back_we), 32'(e_back));
        check_eq({tag, ".halted"}, 32'(halted), 32'(m_halted));
        check_eq({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
        check_eq({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
        @(posedge CLK);
        model_commit();
        #1;
    endtask

    // Asynchronous reset pulse starting mid-cycle; returns just after a rising edge.
    task automatic do_reset(input string tag);
        #2;
        RST = 1'b0;
        #1;
        check_eq({tag, ".rst_pc_we"}, 32'(pc_we), 32'd0);
        check_eq({tag, ".rst_ifid_we"}, 32'(ifid_we), 32'd0);
        check_eq({tag, ".rst_back_we"}, 32'(back_we), 32'd0);
        check_eq({tag, ".rst_ifid_flush"}, 32'(ifid_flush), 32'd1);
        check_eq({tag, ".rst_idex_bubble"}, 32'(idex_bubble), 32'd1);
        check_eq({tag, ".rst_halted"}, 32'(halted), 32'd0);
        check_eq({tag, ".rst_stall_cnt"}, 32'(stall_cnt), 32'd0);
        check_eq({tag, ".rst_flush_cnt"}, 32'(flush_cnt), 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        model_reset();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST = 1'b0;
        set_idle();
        model_reset();
        #1;
        check_eq("por.pc_we", 32'(pc_we), 32'd0);
        check_eq("por.ifid_flush", 32'(ifid_flush), 32'd1);
        check_eq("por.idex_bubble", 32'(idex_bubble), 32'd1);
        check_eq("por.stall_cnt", 32'(stall_cnt), 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b1;

        // Load-use, then same with rd = 0
        run_cycle("idle0");
        set_in(5, 0, 1'b1, 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
        run_cycle("lu");
        check_eq("lu.cnt", 32'(stall_cnt), 32'd1);
        set_in(0, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_cycle("lu_r0");
        check_eq("lu_r0.cnt", 32'(stall_cnt), 32'd1);

        // Taken branch, then branch together with load-use
        set_in(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_cycle("br");
        check_eq("br.cnt", 32'(flush_cnt), 32'd1);
        set_in(0, 7, 1'b0, 1'b1, 7, 1'b1, 1'b1, 1'b0, 1'b0);
        run_cycle("br_lu");
        check_eq("br_lu.flush", 32'(flush_cnt), 32'd2);
        check_eq("br_lu.stall", 32'(stall_cnt), 32'd1);

        // Three-cycle freeze
        set_in(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) run_cycle("frz");
        set_idle();
        run_cycle("frz_end");
        check_eq("frz.cnt", 32'(stall_cnt), 32'd4);

        // Branch arriving with a two-cycle freeze
        set_in(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_cycle("bf0");
        set_in(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_cycle("bf1");
        set_idle();
        run_cycle("bf2");
        check_eq("bf.flush", 32'(flush_cnt), 32'd3);

        // Reset during a pending flush drops it
        set_in(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_cycle("rp0");
        set_idle();
        do_reset("rp");
        run_cycle("rp_after");
        check_eq("rp.noflush", 32'(flush_cnt), 32'd0);

        // Counter saturation
        set_in(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) run_cycle("sat");
        check_eq("sat.cnt", 32'(stall_cnt), 32'd15);
        set_idle();
        run_cycle("sat_end");

        // Halt
        set_in(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_cycle("halt0");
        check_eq("halt.flag", 32'(halted), 32'd1);
        set_in(3, 3, 1'b1, 1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) run_cycle("halted");
        do_reset("post_halt");

        // Randomised traffic against the model
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rnd_rst");
            end else begin
                set_in(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
                       ($urandom_range(0, 149) == 0));
                run_cycle("rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
